// File: rtl/load_store_unit.sv
// Load/store stage: turns an ALU effective address plus store data into a single
// word-wide memory access with byte lanes, load extension, alignment and bus-timeout checks.

package load_store_unit_pkg;
    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } lsu_size_e;

    typedef struct packed {
        logic      store;
        logic      uns;
        lsu_size_e size;
    } lsu_op_t;
endpackage

module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_align,
    output logic        err_bus,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned    CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    lsu_op_t          lat_op, lat_op_nxt;
    logic [1:0]       lat_off, lat_off_nxt;

    logic        busy_nxt, done_nxt, err_align_nxt, err_bus_nxt;
    logic [31:0] rdata_nxt;
    logic        mem_req_nxt, mem_we_nxt;
    logic [31:0] mem_addr_nxt, mem_wdata_nxt;
    logic [3:0]  mem_be_nxt;

    lsu_op_t op_in;
    logic    req_ok;

    assign op_in = lsu_op_t'(op);

    // Legal size with a naturally aligned address
    always_comb begin
        req_ok = 1'b0;
        case (op_in.size)
            SZ_BYTE: req_ok = 1'b1;
            SZ_HALF: req_ok = (addr[0] == 1'b0);
            SZ_WORD: req_ok = (addr[1:0] == 2'b00);
            default: req_ok = 1'b0;
        endcase
    end

    function automatic logic [3:0] store_be(input lsu_size_e sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: store_be = 4'(4'b0001 << off);
            SZ_HALF: store_be = off[1] ? 4'b1100 : 4'b0011;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input lsu_size_e sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: store_data = {4{wd[7:0]}};
            SZ_HALF: store_data = {2{wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    // Pick the addressed lane out of the read word and extend it to 32 bits
    function automatic logic [31:0] load_extract(input lsu_op_t o, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (o.size)
            SZ_BYTE: load_extract = o.uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extract = o.uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: load_extract = w;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_op    <= '0;
            lat_off   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rdata     <= '0;
            err_align <= 1'b0;
            err_bus   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lat_op    <= lat_op_nxt;
            lat_off   <= lat_off_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rdata     <= rdata_nxt;
            err_align <= err_align_nxt;
            err_bus   <= err_bus_nxt;
            mem_req   <= mem_req_nxt;
            mem_we    <= mem_we_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_be    <= mem_be_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    // Next state and next values of every registered output
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = '0;
        lat_op_nxt    = lat_op;
        lat_off_nxt   = lat_off;
        busy_nxt      = 1'b0;
        done_nxt      = 1'b0;
        rdata_nxt     = rdata;
        err_align_nxt = 1'b0;
        err_bus_nxt   = 1'b0;
        mem_req_nxt   = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = '0;
        mem_be_nxt    = '0;
        mem_wdata_nxt = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    lat_op_nxt  = op_in;
                    lat_off_nxt = addr[1:0];
                    busy_nxt    = 1'b1;
                    if (req_ok) begin
                        state_nxt     = ACCESS;
                        mem_req_nxt   = 1'b1;
                        mem_we_nxt    = op_in.store;
                        mem_addr_nxt  = {addr[31:2], 2'b00};
                        mem_be_nxt    = op_in.store ? store_be(op_in.size, addr[1:0]) : 4'b1111;
                        mem_wdata_nxt = op_in.store ? store_data(op_in.size, wdata) : 32'h0;
                    end else begin
                        state_nxt     = RESP;
                        done_nxt      = 1'b1;
                        err_align_nxt = 1'b1;
                        rdata_nxt     = '0;
                    end
                end
            end
            ACCESS: begin
                busy_nxt = 1'b1;
                // An ack in the last timeout cycle still completes normally
                if (mem_ack) begin
                    state_nxt = RESP;
                    done_nxt  = 1'b1;
                    rdata_nxt = lat_op.store ? 32'h0 : load_extract(lat_op, lat_off, mem_rdata);
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = RESP;
                    done_nxt    = 1'b1;
                    err_bus_nxt = 1'b1;
                    rdata_nxt   = '0;
                end else begin
                    cnt_nxt       = cnt + CNT_W'(1);
                    mem_req_nxt   = 1'b1;
                    mem_we_nxt    = mem_we;
                    mem_addr_nxt  = mem_addr;
                    mem_be_nxt    = mem_be;
                    mem_wdata_nxt = mem_wdata;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a lane/extension model
// built from byte-shift arithmetic.

module tb_load_store_unit;

    localparam int unsigned TO = 16;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;
    localparam logic [3:0] OP_BAD = 4'b0011;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        err_align;
    logic        err_bus;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .err_align (err_align),
        .err_bus   (err_bus),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Reference rules: size = 1 << op[1:0] bytes, address must be a multiple of it
    function automatic bit m_legal(input logic [3:0] o, input logic [31:0] a);
        int unsigned sz;
        sz = 32'(o[1:0]);
        if (sz == 3) return 1'b0;
        return (a % (32'd1 << sz)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [3:0] o, input logic [31:0] a);
        if (!o[3]) return 4'hF;
        case (o[1:0])
            2'd0:    return 4'(32'd1 << (a % 4));
            2'd1:    return 4'(32'd3 << (a % 4));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] o, input logic [31:0] wd);
        if (!o[3]) return 32'h0;
        case (o[1:0])
            2'd0:    return (wd & 32'hFF) * 32'h01010101;
            2'd1:    return (wd & 32'hFFFF) * 32'h00010001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] word);
        logic [31:0] v;
        if (o[3]) return 32'h0;
        v = word >> (8 * (a % 4));
        case (o[1:0])
            2'd0: begin
                v = v & 32'hFF;
                if (!o[2] && v >= 32'd128) v = v - 32'd256;
            end
            2'd1: begin
                v = v & 32'hFFFF;
                if (!o[2] && v >= 32'd32768) v = v - 32'd65536;
            end
            default: ;
        endcase
        return v;
    endfunction

    // One access: start in cycle 0, ack in cycle ack_at (<=0 never), check every cycle to done+1
    task automatic run_txn(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                           input int ack_at, input logic [31:0] word, input bit spam,
                           output logic [31:0] got_rdata);
        bit          legal;
        bit          acked;
        int          done_cyc;
        logic [31:0] exp_rd;
        legal    = m_legal(o, a);
        acked    = legal && ack_at >= 1 && ack_at <= int'(TO);
        done_cyc = !legal ? 1 : (acked ? ack_at + 1 : int'(TO) + 1);
        exp_rd   = (legal && acked) ? m_rdata(o, a, word) : 32'h0;

        start = 1'b1; op = o; addr = a; wdata = wd; mem_ack = 1'b0;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            @(posedge clock); #1;
            start = (spam && c <= done_cyc) ? 1'($urandom_range(0, 1)) : 1'b0;
            op    = 4'($urandom);
            addr  = $urandom;
            wdata = $urandom;
            chkb("mem_req", mem_req, 1'(legal && c < done_cyc));
            chkb("busy", busy, 1'(c <= done_cyc));
            chkb("done", done, 1'(c == done_cyc));
            if (legal && c < done_cyc) begin
                chkb("mem_we", mem_we, o[3]);
                chk("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("mem_be", 32'(mem_be), 32'(m_be(o, a)));
                chk("mem_wdata", mem_wdata, m_wdata(o, wd));
            end
            chkb("err_align", err_align, 1'(c == done_cyc && !legal));
            chkb("err_bus", err_bus, 1'(c == done_cyc && legal && !acked));
            if (c >= done_cyc) chk("rdata", rdata, exp_rd);
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? word : $urandom;
        end
        mem_ack   = 1'b0;
        got_rdata = rdata;
    endtask

    initial begin
        logic [31:0] rd;
        logic [3:0]  ro;
        logic [31:0] ra;
        int          r;
        int          ack_at;

        reset_n = 1'b0; start = 1'b0; op = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #12;
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_done", done, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chkb("rst_err_align", err_align, 1'b0);
        chkb("rst_err_bus", err_bus, 1'b0);
        chkb("rst_mem_req", mem_req, 1'b0);
        chkb("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", 32'(mem_be), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        run_txn(OP_LW, 32'h100, 32'h0, 1, 32'hDEADBEEF, 1'b0, rd);
        chk("lw_const", rd, 32'hDEADBEEF);
        run_txn(OP_LB, 32'h103, 32'h0, 1, 32'h80ABCDEF, 1'b0, rd);
        chk("lb_const", rd, 32'hFFFFFF80);
        run_txn(OP_LBU, 32'h103, 32'h0, 2, 32'h80ABCDEF, 1'b0, rd);
        chk("lbu_const", rd, 32'h00000080);
        run_txn(OP_LH, 32'h102, 32'h0, 1, 32'h80011234, 1'b0, rd);
        chk("lh_const", rd, 32'hFFFF8001);
        run_txn(OP_LHU, 32'h102, 32'h0, 1, 32'h80011234, 1'b0, rd);
        chk("lhu_const", rd, 32'h00008001);
        run_txn(OP_SB, 32'h201, 32'h12345678, 1, 32'h0, 1'b0, rd);
        run_txn(OP_SH, 32'h202, 32'h12345678, 3, 32'h0, 1'b0, rd);
        run_txn(OP_SW, 32'h204, 32'h12345678, 1, 32'h0, 1'b0, rd);
        run_txn(OP_LW, 32'h102, 32'h0, 1, 32'h0, 1'b0, rd);
        run_txn(OP_LH, 32'h101, 32'h0, 1, 32'h0, 1'b0, rd);
        run_txn(OP_BAD, 32'h100, 32'h0, 1, 32'h0, 1'b0, rd);
        run_txn(OP_LW, 32'h400, 32'h0, -1, 32'h0, 1'b0, rd);
        run_txn(OP_LW, 32'h404, 32'h0, int'(TO), 32'hCAFEF00D, 1'b0, rd);
        chk("ack_last_const", rd, 32'hCAFEF00D);
        run_txn(OP_LW, 32'h408, 32'h0, int'(TO) + 1, 32'h0, 1'b0, rd);
        run_txn(OP_SW, 32'h40C, 32'hA5A5A5A5, 4, 32'h0, 1'b1, rd);
        run_txn(OP_LB, 32'h401, 32'h0, 1, 32'h0, 1'b1, rd);

        for (int d = 0; d <= 5; d++) begin
            run_txn(OP_LH, 32'h500 + 32'(2 * d), 32'h0, d + 1, $urandom, 1'b0, rd);
        end

        // Reset while a load is waiting for its ack
        start = 1'b1; op = OP_LW; addr = 32'h300;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chkb("mid_rst_req_before", mem_req, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chkb("mid_rst_req_async", mem_req, 1'b0);
        chkb("mid_rst_busy_async", busy, 1'b0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 32'h11111111;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chkb("mid_rst_no_done", done, 1'b0);
            chkb("mid_rst_no_req", mem_req, 1'b0);
        end
        mem_ack = 1'b0;

        for (int n = 0; n < 40; n++) begin
            ro = 4'($urandom);
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra = ra & 32'hFFFF_FFFC;
            r = int'($urandom_range(0, 9));
            if (r < 8)       ack_at = int'($urandom_range(1, 6));
            else if (r == 8) ack_at = -1;
            else             ack_at = int'(TO);
            run_txn(ro, ra, $urandom, ack_at, $urandom, 1'($urandom_range(0, 1)), rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
